// File: rtl/demux_deser_4ch.sv
// demux_deser_4ch: samples a 1-to-4 demux (a/b/c/d + sel) and rebuilds W-bit
// words per channel, MSB first. Completed words leave one at a time on a
// valid/ready port tagged with their channel. Round-robin picks among full
// channels. A sticky err flags any non-selected line seen high.

// Per-channel deserializer: shift register, bit counter, full flag.
module demux_deser_4ch_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift,
  input  logic         din,
  input  logic         clr,
  output logic [W-1:0] sr,
  output logic         full
);
  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt;

  // Shift in accepted bits; the W-th bit freezes the word until it is granted.
  // shift is only ever asserted while !full and clr only while full, so the
  // two never collide on one lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      cnt  <= '0;
      full <= 1'b0;
    end else if (shift) begin
      sr <= {sr[W-2:0], din};
      if (cnt == CW'(W - 1)) begin
        full <= 1'b1;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (clr) begin
      full <= 1'b0;
    end
  end
endmodule

module demux_deser_4ch #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [1:0]   sel,
  input  logic         a,
  input  logic         b,
  input  logic         c,
  input  logic         d,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_ch,
  output logic [W-1:0] out_data,
  output logic         err
);
  localparam int NCH = 4;

  logic [NCH-1:0]        lines;
  logic [NCH-1:0]        sel_oh;
  logic [NCH-1:0]        full;
  logic [NCH-1:0]        shift;
  logic [NCH-1:0]        clr;
  logic [NCH-1:0][W-1:0] sr;
  logic                  acc;
  logic                  din;
  logic                  load;
  logic                  gnt_any;
  logic [1:0]            gnt_ch;
  logic [1:0]            idx;
  logic [1:0]            rr_ptr;

  assign lines    = {d, c, b, a};
  assign sel_oh   = NCH'(1) << sel;
  assign in_ready = !full[sel];
  assign acc      = in_valid && in_ready;
  assign din      = lines[sel];
  assign shift    = acc ? sel_oh : '0;

  // Output register is free when empty or being drained this cycle.
  assign load = (!out_valid || out_ready) && gnt_any;
  assign clr  = load ? (NCH'(1) << gnt_ch) : '0;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    demux_deser_4ch_lane #(.W(W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .shift (shift[g]),
      .din   (din),
      .clr   (clr[g]),
      .sr    (sr[g]),
      .full  (full[g])
    );
  end

  // Round-robin scan: first full channel at rr_ptr, rr_ptr+1, ... (mod 4).
  // Iterating farthest-first lets the nearest hit overwrite the result.
  always_comb begin
    gnt_any = 1'b0;
    gnt_ch  = rr_ptr;
    idx     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = rr_ptr + 2'(i);
      if (full[idx]) begin
        gnt_any = 1'b1;
        gnt_ch  = idx;
      end
    end
  end

  // Output register: load a granted word, or drop valid once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_ch    <= gnt_ch;
      out_data  <= sr[gnt_ch];
      rr_ptr    <= gnt_ch + 2'd1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky line check: any non-selected line high while in_valid.
  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (in_valid && |(lines & ~sel_oh))
      err <= 1'b1;
  end
endmodule

// File: tb/tb_demux_deser_4ch.sv
// Self-checking bench for demux_deser_4ch: directed scenarios against
// constants plus a randomized run compared against a word-level model.
module tb_demux_deser_4ch;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready, a, b, c, d;
  logic [1:0]   sel;
  logic         in_ready, out_valid, err;
  logic [1:0]   out_ch;
  logic [W-1:0] out_data;

  int checks = 0;
  int errors = 0;

  // Reference model state (word-level, integer arithmetic)
  int  m_cnt  [4];
  int  m_word [4];
  bit  m_full [4];
  bit  m_ov;
  int  m_och;
  int  m_od;
  int  m_rr;
  bit  m_err;

  demux_deser_4ch #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sel(sel),
    .a(a), .b(b), .c(c), .d(d), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_data(out_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic drive(input bit r, input bit iv, input int s, input logic [3:0] ln, input bit ordy);
    rst = r; in_valid = iv; sel = s[1:0]; {d, c, b, a} = ln; out_ready = ordy;
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    logic [3:0] ln;
    logic [3:0] sm;
    int  k, g;
    bit  acc, bt;
    ln = {d, c, b, a};
    k  = int'(sel);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_word[i] = 0; m_full[i] = 0; end
      m_ov = 0; m_och = 0; m_od = 0; m_rr = 0; m_err = 0;
    end else begin
      sm  = 4'b0001 << k;
      acc = in_valid && !m_full[k];
      bt  = ln[k];
      if (in_valid && (ln & ~sm) != 4'b0) m_err = 1;
      if (!m_ov || out_ready) begin
        g = -1;
        for (int i = 0; i < 4; i++)
          if (g < 0 && m_full[(m_rr + i) % 4]) g = (m_rr + i) % 4;
        if (g >= 0) begin
          m_ov = 1; m_och = g; m_od = m_word[g]; m_full[g] = 0; m_rr = (g + 1) % 4;
        end else begin
          m_ov = 0;
        end
      end
      if (acc) begin
        m_word[k] = (m_word[k] * 2 + int'(bt)) % (1 << W);
        m_cnt[k]  = m_cnt[k] + 1;
        if (m_cnt[k] == W) begin m_full[k] = 1; m_cnt[k] = 0; end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input int ch, input logic [W-1:0] w, input bit ordy);
    logic [3:0] ln;
    for (int i = W - 1; i >= 0; i--) begin
      ln = 4'(w[i]) << ch;
      drive(0, 1, ch, ln, ordy);
      tick();
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 4'b0, 0);
    tick(); tick();
    drive(0, 0, 0, 4'b0, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch got %0d exp 0", out_ch); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
    for (int s = 0; s < 4; s++) begin
      drive(0, 0, s, 4'b0, 0);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready sel=%0d got %b exp 1", s, in_ready); end
    end
  endtask

  task automatic test_single_word();
    send_word(2, 8'hB2, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", out_valid); end
    drive(0, 0, 0, 4'b0, 1);
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
    checks++; if (out_ch !== 2'd2) begin errors++; $display("FAIL single_ch got %0d exp 2", out_ch); end
    checks++; if (out_data !== 8'hB2) begin errors++; $display("FAIL single_data got %0h exp b2", out_data); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %b exp 0", out_valid); end
  endtask

  task automatic test_interleave();
    for (int i = 0; i < W; i++) begin
      drive(0, 1, 0, 4'b0001, 0); tick();
      drive(0, 1, 1, 4'b0000, 0); tick();
    end
    drive(0, 0, 0, 4'b0, 0);
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'hFF) begin
      errors++; $display("FAIL rr_first got v=%b ch=%0d d=%0h exp v=1 ch=0 d=ff", out_valid, out_ch, out_data); end
    drive(0, 0, 0, 4'b0, 1);
    tick();
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h00) begin
      errors++; $display("FAIL rr_second got v=%b ch=%0d d=%0h exp v=1 ch=1 d=00", out_valid, out_ch, out_data); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    send_word(3, 8'h5A, 0);
    drive(0, 0, 0, 4'b0, 0);
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
      errors++; $display("FAIL bp_first got v=%b d=%0h exp v=1 d=5a", out_valid, out_data); end
    send_word(3, 8'hC3, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 3, 4'b1000, 0);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 8'h5A) begin
        errors++; $display("FAIL bp_hold got v=%b ch=%0d d=%0h exp v=1 ch=3 d=5a", out_valid, out_ch, out_data); end
    end
    drive(0, 0, 3, 4'b0, 1);
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hC3) begin
      errors++; $display("FAIL bp_second got v=%b d=%0h exp v=1 d=c3", out_valid, out_data); end
    drive(0, 0, 3, 4'b0, 0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", in_ready); end
    send_word(3, 8'h81, 1);
    drive(0, 0, 0, 4'b0, 1);
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h81) begin
      errors++; $display("FAIL bp_fresh got v=%b d=%0h exp v=1 d=81", out_valid, out_data); end
    tick();
  endtask

  task automatic test_line_error();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pre got %b exp 0", err); end
    drive(0, 1, 1, 4'b0001, 1);
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err); end
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, i % 4, 4'(1) << (i % 4), 1);
      tick();
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
  endtask

  task automatic test_reset_midword();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 4'(1), 1);
      tick();
    end
    drive(1, 1, 0, 4'(1), 1);
    tick();
    checks++; if (err !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset got err=%b v=%b exp 0 0", err, out_valid); end
    send_word(0, 8'h3C, 1);
    drive(0, 0, 0, 4'b0, 1);
    tick();
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h3C) begin
      errors++; $display("FAIL mid_word got v=%b ch=%0d d=%0h exp v=1 ch=0 d=3c", out_valid, out_ch, out_data); end
  endtask

  task automatic test_random();
    logic [3:0] ln;
    int s;
    drive(1, 0, 0, 4'b0, 0);
    tick();
    for (int n = 0; n < 3000; n++) begin
      s  = $urandom_range(0, 3);
      ln = 4'($urandom_range(0, 1)) << s;
      if ($urandom_range(0, 24) == 0) ln = ln | 4'($urandom);
      drive(($urandom_range(0, 399) == 0), ($urandom_range(0, 3) != 0), s, ln, ($urandom_range(0, 1) == 1));
      #1;
      checks++; if (in_ready !== !m_full[s]) begin
        errors++; $display("FAIL rnd_in_ready n=%0d got %b exp %b", n, in_ready, !m_full[s]); end
      tick();
      checks++; if (out_valid !== m_ov) begin
        errors++; $display("FAIL rnd_valid n=%0d got %b exp %b", n, out_valid, m_ov); end
      checks++; if (out_ch !== 2'(m_och) || out_data !== W'(m_od)) begin
        errors++; $display("FAIL rnd_word n=%0d got ch=%0d d=%0h exp ch=%0d d=%0h", n, out_ch, out_data, m_och, m_od); end
      checks++; if (err !== m_err) begin
        errors++; $display("FAIL rnd_err n=%0d got %b exp %b", n, err, m_err); end
    end
  endtask

  initial begin
    drive(1, 0, 0, 4'b0, 0);
    test_reset();
    test_single_word();
    test_interleave();
    test_backpressure();
    test_line_error();
    test_reset_midword();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
